pipeline_stage: RTL and testbench

PIPELINE_STAGE -- requirements
Module: pipeline_stage

---
 rtl/types_pkg.sv | 12 +
 rtl/sat_counter.sv | 19 +
 rtl/pipeline_stage.sv | 105 ++++++++++
 tb/tb_pipeline_stage.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/types_pkg.sv
// Shared types for the pipeline register slice: occupancy states and perf counter width.
package types_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  localparam int unsigned PERF_W = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stage.sv
// Two-entry register slice (main + skid) with flush and optional perf counters.
// Perf counters are built only when PIPELINE_STAGE_PERF_EN is defined; otherwise they read 0.
module pipeline_stage
  import types_pkg::*;
#(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  parameter int unsigned       PERF_W    = types_pkg::PERF_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] bubble_cnt
);

  pipe_state_e      state, state_next;
  logic [WIDTH-1:0] main_q, main_next;
  logic [WIDTH-1:0] skid_q, skid_next;
  logic             in_ready_q;
  logic             in_xfer, out_xfer;

  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign in_ready  = in_ready_q;
  assign in_xfer   = in_valid && in_ready_q;
  assign out_xfer  = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= EMPTY;
      main_q     <= RESET_VAL;
      skid_q     <= RESET_VAL;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_next;
      main_q     <= main_next;
      skid_q     <= skid_next;
      in_ready_q <= (state_next != FULL);
    end
  end

  always_comb begin
    state_next = state;
    main_next  = main_q;
    skid_next  = skid_q;
    unique case (state)
      EMPTY: begin
        if (in_xfer) begin
          state_next = HALF;
          main_next  = in_data;
        end
      end
      HALF: begin
        if (in_xfer && out_xfer) begin
          main_next = in_data;
        end else if (in_xfer) begin
          state_next = FULL;
          skid_next  = in_data;
        end else if (out_xfer) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          state_next = HALF;
          main_next  = skid_q;
        end
      end
      default: state_next = EMPTY;
    endcase
    // Flush only drops occupancy; payload registers keep their contents.
    if (flush) begin
      state_next = EMPTY;
      main_next  = main_q;
      skid_next  = skid_q;
    end
  end

`ifdef PIPELINE_STAGE_PERF_EN
  sat_counter #(.W(PERF_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (out_valid && !out_ready),
    .count (stall_cnt)
  );

  sat_counter #(.W(PERF_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (!out_valid),
    .count (bubble_cnt)
  );
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_stage.sv
// Directed and randomized self-checking bench for pipeline_stage (honours PIPELINE_STAGE_PERF_EN).
module tb_pipeline_stage;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned PERF_W    = 4;
  localparam logic [31:0] RESET_VAL = 32'hDEAD_BEEF;
  localparam int          CNT_MAX   = 15;
`ifdef PIPELINE_STAGE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic [PERF_W-1:0] stall_cnt;
  logic [PERF_W-1:0] bubble_cnt;

  int checks   = 0;
  int failures = 0;

  logic [31:0] q[$];
  int stall_m;
  int bubble_m;

  pipeline_stage #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL),
    .PERF_W    (PERF_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge, keeping the reference occupancy/counter model in step.
  task automatic cycle();
    bit          ix, ox;
    logic [31:0] d;
    ix = in_valid && (q.size() < 2);
    ox = (q.size() > 0) && out_ready;
    d  = in_data;
    if (q.size() > 0 && !out_ready && stall_m < CNT_MAX) stall_m++;
    if (q.size() == 0 && bubble_m < CNT_MAX) bubble_m++;
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (ox) void'(q.pop_front());
      if (ix) q.push_back(d);
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_ovalid"}, 32'(out_valid), 32'(q.size() > 0));
    check({tag, "_iready"}, 32'(in_ready), 32'(q.size() < 2));
    if (q.size() > 0) check({tag, "_odata"}, out_data, q[0]);
    check({tag, "_stall"}, 32'(stall_cnt), PERF ? 32'(stall_m) : 32'd0);
    check({tag, "_bubble"}, 32'(bubble_cnt), PERF ? 32'(bubble_m) : 32'd0);
  endtask

  task automatic model_reset();
    q.delete();
    stall_m  = 0;
    bubble_m = 0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    model_reset();
    #12;
    check("rst_ovalid", 32'(out_valid), 32'd0);
    check("rst_iready", 32'(in_ready), 32'd1);
    check("rst_odata", out_data, RESET_VAL);
    check("rst_stall", 32'(stall_cnt), 32'd0);
    check("rst_bubble", 32'(bubble_cnt), 32'd0);
    @(negedge clk); reset = 1'b0;

    // three idle cycles
    repeat (3) cycle();
    check("idle_bubble", 32'(bubble_cnt), PERF ? 32'd3 : 32'd0);

    // streaming 1..4
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = 32'(i);
      cycle();
      check("stream_ovalid", 32'(out_valid), 32'd1);
      check("stream_odata", out_data, 32'(i));
      check("stream_iready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    cycle();
    check("stream_drain", 32'(out_valid), 32'd0);

    // back-pressure A,B
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
    cycle();
    check("bp_half_data", out_data, 32'hA);
    check("bp_half_iready", 32'(in_ready), 32'd1);
    in_data = 32'hB;
    cycle();
    check("bp_full_iready", 32'(in_ready), 32'd0);
    check("bp_full_data", out_data, 32'hA);
    in_data = 32'hEE;
    cycle();
    check("bp_hold_data", out_data, 32'hA);
    check("bp_hold_iready", 32'(in_ready), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    check("bp_b_data", out_data, 32'hB);
    check("bp_b_iready", 32'(in_ready), 32'd1);
    cycle();
    check("bp_empty", 32'(out_valid), 32'd0);

    // flush while FULL with C offered
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1A;
    cycle();
    in_data = 32'h1B;
    cycle();
    in_data = 32'h1C; flush = 1'b1;
    cycle();
    check("fl_ovalid", 32'(out_valid), 32'd0);
    check("fl_iready", 32'(in_ready), 32'd1);
    check("fl_payload_kept", out_data, 32'h1A);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    check("fl_no_c", 32'(out_valid), 32'd0);

    // long stall saturates
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h55;
    cycle();
    in_valid = 1'b0;
    repeat (20) cycle();
    check("stall_sat", 32'(stall_cnt), PERF ? 32'd15 : 32'd0);
    check("stall_hold_data", out_data, 32'h55);

    // async reset between edges while HALF
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b1; in_data = 32'h77; out_ready = 1'b0;
    cycle();
    check("ar_pre_ovalid", 32'(out_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("ar_ovalid", 32'(out_valid), 32'd0);
    check("ar_odata", out_data, RESET_VAL);
    check("ar_iready", 32'(in_ready), 32'd1);
    check("ar_stall", 32'(stall_cnt), 32'd0);
    check("ar_bubble", 32'(bubble_cnt), 32'd0);
    model_reset();
    in_valid = 1'b1; in_data = 32'h99; out_ready = 1'b1;
    @(negedge clk); reset = 1'b0;
    cycle();
    check("ar_post_data", out_data, 32'h99);
    check("ar_post_ovalid", 32'(out_valid), 32'd1);

    // randomized traffic against the queue model
    for (int n = 0; n < 3000; n++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      flush     = ($urandom_range(0, 31) == 0);
      cycle();
      check_model("rnd");
    end
    flush = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
